encoder_scan8: RTL and testbench
================================

Name: encoder_scan8

Overview:
- Sequential 8-to-3 priority encoder. It is the inverse companion of the team's 3-to-8 enabled decoder (inputs e, a, b, c; outputs d0..d7).
- Captures an 8-bit one-hot or multi-hot request vector and emits, one per handshake, the binary index of every set bit, highest index first.
- Ends each job with a done pulse.
- Sits between request sources and the decoder. An emitted code fed back through the decoder with e=1 reproduces the served bit.

Parameters:
- N, 8, number of request inputs; only 8 is supported.
- W, 3, code width; equals log2(N).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- e  input  1  enable; deasserting it aborts any job in progress
- d  input  N  request vector; bit i corresponds to decoder output di
- load  input  1  capture request; sampled only in IDLE with e=1
- rdy  input  1  downstream ready for the current code
- code  output  W  index of the highest pending bit; code[2:0] maps to decoder a, b, c (a = MSB)
- v  output  1  code valid
- busy  output  1  high in SCAN or DONE
- done  output  1  one-cycle pulse at job end
- z  output  1  high together with done when the captured vector was 0

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous, active-low, one clock domain. While rst_n=0: state=IDLE, pend=0, code=0, v=0, busy=0, done=0, z=0. Reset takes effect immediately, including mid-job; the job is discarded and no done is produced.
- Output style: all outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- IDLE:
  - v=0, busy=0, code=0.
  - On an edge with e=1 and load=1: pend<=d.
  - If d!=0, go to SCAN. If d==0, go to DONE with z<=1.
  - load with e=0 is ignored.
- SCAN:
  - v=1, busy=1, code = highest i with pend[i]=1.
  - First valid code appears in the cycle after the load edge (latency 1).
  - Handshake: a transfer occurs on an edge with v=1, rdy=1 and e=1. That edge clears pend[code].
  - If the cleared pend is 0, go to DONE. Otherwise stay in SCAN, and the next code appears the following cycle.
  - Back-to-back transfers run at one code per cycle when rdy stays high.
  - With rdy=0, code and v hold stable. Changes on d have no effect while busy.
  - e=0 on any edge: go to IDLE, pend<=0, v drops the next cycle, no done pulse. This abort overrides a simultaneous rdy=1, so that code is not counted as transferred.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - z clears when leaving DONE.
  - load during DONE is ignored.
- Ordering and count: codes are emitted strictly descending (7 down to 0). The number of transfers equals popcount(captured d). The same index is never emitted twice per job.
- Timing:
  - Minimum job length is 1 + popcount + 1 cycles from the load edge to returning to IDLE.
  - A new load is accepted on the first IDLE cycle after done.

Test Plan:
- Reset mid-SCAN: load d=8'b0110_0000, then pull rst_n low asynchronously between edges. Required: v, busy, done, code drop to 0 immediately, and no done ever follows.
- Single one-hot with rdy=1: e=1, load d=8'b0001_0000. Required: next cycle v=1, code=4. Following cycle done=1, z=0, v=0. Decoder fed code with e=1 asserts only d4.
- Multi-hot with rdy=1: load d=8'b1010_0101. Required: codes 7, 5, 2, 0 on four consecutive cycles, then done pulse. Exactly 4 transfers.
- Backpressure: load d=8'b1000_0010, hold rdy=0 for 5 cycles. Required: code=7, v=1 stable throughout. Raising rdy then yields 1, then done.
- Empty vector and ignored loads: load d=0. Required: done=1, z=1 the next cycle, no v. A load with e=0, and a load during SCAN, are ignored (pend and output unchanged).
- Abort: load d=8'hFF, transfer 7 and 6, then drop e on the same edge as rdy=1 with code=5. Required: IDLE next cycle, v=0, no done. A fresh load d=8'h01 then gives code=0 and done.

Source files
------------

// File: rtl/encoder_scan8.sv
// Sequential 8-to-3 priority encoder: captures a request vector and emits the
// index of every set bit, highest first, one per ready/valid transfer.
module encoder_scan8 #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e,
  input  logic [N-1:0] d,
  input  logic         load,
  input  logic         rdy,
  output logic [W-1:0] code,
  output logic         v,
  output logic         busy,
  output logic         done,
  output logic         z
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pend_q,  pend_d;
  logic         z_q,     z_d;

  logic [W-1:0] top_idx;
  logic [N-1:0] pend_cleared;

  // Highest set bit of the pending vector; later iterations win.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) top_idx = W'(i);
    end
  end

  assign pend_cleared = pend_q & ~(N'(1) << top_idx);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    z_d     = z_q;
    unique case (state_q)
      ST_IDLE: begin
        if (e && load) begin
          pend_d = d;
          if (d != '0) begin
            state_d = ST_SCAN;
          end else begin
            state_d = ST_DONE;
            z_d     = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        // Abort wins over a simultaneous handshake: that code is not transferred.
        if (!e) begin
          state_d = ST_IDLE;
          pend_d  = '0;
        end else if (rdy) begin
          pend_d = pend_cleared;
          if (pend_cleared == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        z_d     = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = '0;
        z_d     = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      z_q     <= z_d;
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  assign v    = (state_q == ST_SCAN);
  assign busy = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign done = (state_q == ST_DONE);
  assign z    = z_q;
  assign code = v ? top_idx : '0;

endmodule

// File: tb/tb_encoder_scan8.sv
// Directed bench for encoder_scan8 with hand-computed expectations and a
// small model of the companion 3-to-8 decoder.
module tb_encoder_scan8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e;
  logic [7:0] d;
  logic       load;
  logic       rdy;
  logic [2:0] code;
  logic       v;
  logic       busy;
  logic       done;
  logic       z;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer;

  encoder_scan8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .e     (e),
    .d     (d),
    .load  (load),
    .rdy   (rdy),
    .code  (code),
    .v     (v),
    .busy  (busy),
    .done  (done),
    .z     (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model of the 3-to-8 enabled decoder (a = code[2]).
  function automatic logic [7:0] decode(input logic en, input logic [2:0] c);
    logic [7:0] r;
    r = 8'h00;
    if (en) r[c] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".v"},    {7'd0, v},    8'd0);
    check({tag, ".busy"}, {7'd0, busy}, 8'd0);
    check({tag, ".done"}, {7'd0, done}, 8'd0);
    check({tag, ".code"}, {5'd0, code}, 8'd0);
  endtask

  task automatic check_scan(input string tag, input logic [2:0] exp_code);
    check({tag, ".v"},    {7'd0, v},    8'd1);
    check({tag, ".busy"}, {7'd0, busy}, 8'd1);
    check({tag, ".done"}, {7'd0, done}, 8'd0);
    check({tag, ".code"}, {5'd0, code}, {5'd0, exp_code});
  endtask

  task automatic check_done(input string tag, input logic exp_z);
    check({tag, ".done"}, {7'd0, done}, 8'd1);
    check({tag, ".busy"}, {7'd0, busy}, 8'd1);
    check({tag, ".v"},    {7'd0, v},    8'd0);
    check({tag, ".z"},    {7'd0, z},    {7'd0, exp_z});
  endtask

  initial begin
    logic [2:0] seq_a5 [4];
    seq_a5 = '{3'd7, 3'd5, 3'd2, 3'd0};

    rst_n = 1'b0; e = 1'b0; d = 8'h00; load = 1'b0; rdy = 1'b0;
    tick();
    check_idle("reset");
    check("reset.z", {7'd0, z}, 8'd0);
    rst_n = 1'b1;
    tick();

    // Single one-hot, rdy high.
    e = 1'b1; rdy = 1'b1; d = 8'b0001_0000; load = 1'b1;
    tick();
    load = 1'b0;
    check_scan("onehot", 3'd4);
    check("onehot.dec", decode(1'b1, code), 8'b0001_0000);
    tick();
    check_done("onehot.end", 1'b0);
    tick();
    check_idle("onehot.idle");

    // Multi-hot, back-to-back transfers.
    d = 8'b1010_0101; load = 1'b1;
    tick();
    load = 1'b0;
    n_xfer = 0;
    for (int i = 0; i < 4; i++) begin
      check_scan($sformatf("multi[%0d]", i), seq_a5[i]);
      if (v && rdy) n_xfer++;
      tick();
    end
    check_done("multi.end", 1'b0);
    check("multi.xfers", 8'(n_xfer), 8'd4);
    tick();
    check_idle("multi.idle");

    // Backpressure: code and v hold while rdy is low; d changes are ignored.
    rdy = 1'b0; d = 8'b1000_0010; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h11 << i);
      check_scan($sformatf("bp.hold[%0d]", i), 3'd7);
      tick();
    end
    rdy = 1'b1;
    tick();
    check_scan("bp.next", 3'd1);
    tick();
    check_done("bp.end", 1'b0);
    tick();
    check_idle("bp.idle");

    // Empty vector.
    d = 8'h00; load = 1'b1;
    tick();
    check_done("empty", 1'b1);
    d = 8'h40;                // load still high during DONE: must be ignored
    tick();
    load = 1'b0;
    check_idle("empty.idle");
    check("empty.zclr", {7'd0, z}, 8'd0);
    tick();
    check_idle("empty.after");

    // Load with e low is ignored.
    e = 1'b0; d = 8'hFF; load = 1'b1;
    tick();
    check_idle("load_e0");
    tick();
    check_idle("load_e0.2");

    // Load during SCAN is ignored.
    e = 1'b1; rdy = 1'b0; d = 8'h04; load = 1'b1;
    tick();
    check_scan("scanload.a", 3'd2);
    d = 8'h80;
    tick();
    load = 1'b0;
    check_scan("scanload.b", 3'd2);
    rdy = 1'b1;
    tick();
    check_done("scanload.end", 1'b0);
    tick();
    check_idle("scanload.idle");

    // Abort: e drops on the same edge as a handshake for code 5.
    d = 8'hFF; load = 1'b1;
    tick();
    load = 1'b0;
    check_scan("abort.7", 3'd7);
    tick();
    check_scan("abort.6", 3'd6);
    tick();
    check_scan("abort.5", 3'd5);
    e = 1'b0;
    tick();
    check_idle("abort.idle");
    tick();
    check_idle("abort.nodone");
    e = 1'b1; d = 8'h01; load = 1'b1;
    tick();
    load = 1'b0;
    check_scan("abort.fresh", 3'd0);
    check("abort.dec", decode(1'b1, code), 8'h01);
    tick();
    check_done("abort.fresh.end", 1'b0);
    tick();

    // Asynchronous reset mid-SCAN.
    rdy = 1'b0; d = 8'b0110_0000; load = 1'b1;
    tick();
    load = 1'b0;
    check_scan("rst.pre", 3'd6);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst.async");
    tick();
    rst_n = 1'b1;
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("rst.after[%0d]", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
